// File: rtl/icache_miss_handler.sv
// Instruction-cache miss handler: issues one block read per miss, assembles two
// 32-bit beats into a 64-bit line, and drains fills killed by a backend redirect.
module icache_miss_handler (
   input  logic        clk,
   input  logic        rst,
   input  logic        icache_miss,
   input  logic [31:0] miss_PC,
   input  logic        recovery_PC_valid,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data,
   output logic [63:0] dram_response,
   output logic        dram_response_valid,
   output logic [31:0] fill_PC,
   output logic        busy
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_REQ    = 3'd1;
   localparam logic [2:0] S_BEAT0  = 3'd2;
   localparam logic [2:0] S_BEAT1  = 3'd3;
   localparam logic [2:0] S_FILL   = 3'd4;
   localparam logic [2:0] S_DRAIN0 = 3'd5;
   localparam logic [2:0] S_DRAIN1 = 3'd6;

   logic [2:0]  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] low_q, low_d;
   logic [63:0] resp_q, resp_d;
   logic [31:0] fill_pc_q, fill_pc_d;
   logic        req_valid_q, req_valid_d;
   logic        resp_valid_q, resp_valid_d;
   logic        busy_q, busy_d;

   // Next-state and datapath logic; outputs are decoded from the next state so they come straight from flops.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      low_d     = low_q;
      resp_d    = resp_q;
      fill_pc_d = fill_pc_q;
      case (state_q)
         S_IDLE: begin
            if (icache_miss && !recovery_PC_valid) begin
               state_d = S_REQ;
               addr_d  = {miss_PC[31:3], 3'b000};
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            // A handshake in the redirect cycle still owes DRAM two beats.
            if (mem_req_ready) begin
               state_d = recovery_PC_valid ? S_DRAIN0 : S_BEAT0;
            end else if (recovery_PC_valid) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_REQ;
            end
         end
         S_BEAT0: begin
            if (mem_resp_valid) begin
               low_d   = mem_resp_data;
               state_d = recovery_PC_valid ? S_DRAIN1 : S_BEAT1;
            end else if (recovery_PC_valid) begin
               state_d = S_DRAIN0;
            end else begin
               state_d = S_BEAT0;
            end
         end
         S_BEAT1: begin
            if (mem_resp_valid) begin
               if (recovery_PC_valid) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_FILL;
                  resp_d    = {mem_resp_data, low_q};
                  fill_pc_d = addr_q;
               end
            end else if (recovery_PC_valid) begin
               state_d = S_DRAIN1;
            end else begin
               state_d = S_BEAT1;
            end
         end
         S_FILL: begin
            state_d = S_IDLE;
         end
         S_DRAIN0: begin
            if (mem_resp_valid) begin
               state_d = S_DRAIN1;
            end else begin
               state_d = S_DRAIN0;
            end
         end
         S_DRAIN1: begin
            if (mem_resp_valid) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DRAIN1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      req_valid_d  = (state_d == S_REQ);
      resp_valid_d = (state_d == S_FILL);
      busy_d       = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= 32'd0;
         low_q        <= 32'd0;
         resp_q       <= 64'd0;
         fill_pc_q    <= 32'd0;
         req_valid_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         low_q        <= low_d;
         resp_q       <= resp_d;
         fill_pc_q    <= fill_pc_d;
         req_valid_q  <= req_valid_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign mem_req_valid       = req_valid_q;
   assign mem_req_addr        = addr_q;
   assign dram_response       = resp_q;
   assign dram_response_valid = resp_valid_q;
   assign fill_PC             = fill_pc_q;
   assign busy                = busy_q;

endmodule

// File: tb/tb_icache_miss_handler.sv
// Self-checking bench for icache_miss_handler: directed table, corner-case
// sequences and a randomized run against a transaction-level reference model.
module tb_icache_miss_handler;

   logic        clk = 1'b0;
   logic        rst, icache_miss, recovery_PC_valid, mem_req_ready, mem_resp_valid;
   logic [31:0] miss_PC, mem_resp_data;
   logic        mem_req_valid, dram_response_valid, busy;
   logic [31:0] mem_req_addr, fill_PC;
   logic [63:0] dram_response;

   always #5 clk = ~clk;

   icache_miss_handler dut (
      .clk(clk), .rst(rst), .icache_miss(icache_miss), .miss_PC(miss_PC),
      .recovery_PC_valid(recovery_PC_valid), .mem_req_valid(mem_req_valid),
      .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .dram_response(dram_response), .dram_response_valid(dram_response_valid),
      .fill_PC(fill_PC), .busy(busy)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a pending request, a count of beats still owed, a kill flag.
   bit          m_pending = 1'b0, m_fill = 1'b0, m_killed = 1'b0;
   int          m_beats = 0;
   logic [31:0] m_addr = 32'd0, m_low = 32'd0, m_fill_pc = 32'd0;
   logic [63:0] m_resp = 64'd0;

   typedef struct {
      logic rst, miss; logic [31:0] pc; logic rec, rdy, rv; logic [31:0] rd;
      logic e_req; logic [31:0] e_addr; logic e_dv; logic [63:0] e_resp;
      logic [31:0] e_fpc; logic e_busy;
   } vec_t;
   vec_t tbl[19];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic r, input logic m, input logic [31:0] pc, input logic rc,
                         input logic rdy, input logic rv, input logic [31:0] rd);
      rst = r; icache_miss = m; miss_PC = pc; recovery_PC_valid = rc;
      mem_req_ready = rdy; mem_resp_valid = rv; mem_resp_data = rd;
   endtask

   task automatic model_step();
      bit kill;
      if (rst) begin
         m_pending = 1'b0; m_beats = 0; m_fill = 1'b0; m_killed = 1'b0;
         m_addr = 32'd0; m_resp = 64'd0; m_fill_pc = 32'd0;
      end else if (m_fill) begin
         m_fill = 1'b0;
      end else if (m_pending) begin
         if (mem_req_ready) begin
            m_pending = 1'b0; m_beats = 2; m_killed = recovery_PC_valid;
         end else if (recovery_PC_valid) begin
            m_pending = 1'b0;
         end
      end else if (m_beats > 0) begin
         kill = m_killed || recovery_PC_valid;
         if (mem_resp_valid) begin
            if (m_beats == 2) m_low = mem_resp_data;
            else if (!kill) begin
               m_resp = {mem_resp_data, m_low}; m_fill_pc = m_addr; m_fill = 1'b1;
            end
            m_beats--;
         end
         m_killed = kill;
      end else if (icache_miss && !recovery_PC_valid) begin
         m_addr = miss_PC & 32'hFFFF_FFF8; m_pending = 1'b1;
      end
   endtask

   task automatic model_check();
      chk("model mem_req_valid", {63'd0, mem_req_valid}, {63'd0, m_pending});
      chk("model mem_req_addr", {32'd0, mem_req_addr}, {32'd0, m_addr});
      chk("model dram_response_valid", {63'd0, dram_response_valid}, {63'd0, m_fill});
      chk("model dram_response", dram_response, m_resp);
      chk("model fill_PC", {32'd0, fill_PC}, {32'd0, m_fill_pc});
      chk("model busy", {63'd0, busy}, {63'd0, (m_pending || m_beats != 0 || m_fill)});
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      n_vec++;
      model_check();
   endtask

   localparam logic [63:0] R1 = 64'h00812c23_00112e23;
   localparam logic [63:0] R2 = 64'h12345678_aaaa5555;

   initial begin
      int reqcnt, fill_at;
      bit dv_seen;

      tbl[0]  = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,     1'b0, 64'h0, 32'h0,     1'b0};
      tbl[1]  = '{1'b0, 1'b1, 32'h10194, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10190, 1'b0, 64'h0, 32'h0,     1'b1};
      tbl[2]  = '{1'b0, 1'b1, 32'h10194, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h10190, 1'b0, 64'h0, 32'h0,     1'b1};
      tbl[3]  = '{1'b0, 1'b1, 32'h10194, 1'b0, 1'b0, 1'b1, 32'h00112e23, 1'b0, 32'h10190, 1'b0, 64'h0, 32'h0,     1'b1};
      tbl[4]  = '{1'b0, 1'b1, 32'h10194, 1'b0, 1'b0, 1'b1, 32'h00812c23, 1'b0, 32'h10190, 1'b1, R1,    32'h10190, 1'b1};
      tbl[5]  = '{1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10190, 1'b0, R1,    32'h10190, 1'b0};
      tbl[6]  = '{1'b0, 1'b1, 32'h101a0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h101a0, 1'b0, R1,    32'h10190, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 32'h101a0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h101a0, 1'b0, R1,    32'h10190, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 32'h10300, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h101a0, 1'b0, R1,    32'h10190, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 32'h10304, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10300, 1'b0, R1,    32'h10190, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 32'h10304, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h10300, 1'b0, R1,    32'h10190, 1'b1};
      tbl[11] = '{1'b0, 1'b1, 32'h10304, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10300, 1'b0, R1,    32'h10190, 1'b1};
      tbl[12] = '{1'b0, 1'b1, 32'h10304, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10300, 1'b0, R1,    32'h10190, 1'b1};
      tbl[13] = '{1'b0, 1'b1, 32'h10304, 1'b0, 1'b0, 1'b1, 32'haaaa5555, 1'b0, 32'h10300, 1'b0, R1,    32'h10190, 1'b1};
      tbl[14] = '{1'b0, 1'b1, 32'h10304, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10300, 1'b0, R1,    32'h10190, 1'b1};
      tbl[15] = '{1'b0, 1'b1, 32'h10304, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10300, 1'b0, R1,    32'h10190, 1'b1};
      tbl[16] = '{1'b0, 1'b1, 32'h10304, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 32'h10300, 1'b1, R2,    32'h10300, 1'b1};
      tbl[17] = '{1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h10300, 1'b0, R2,    32'h10300, 1'b0};
      tbl[18] = '{1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 32'hdeadbeef, 1'b0, 32'h10300, 1'b0, R2,    32'h10300, 1'b0};

      for (int i = 0; i < 19; i++) begin
         set_in(tbl[i].rst, tbl[i].miss, tbl[i].pc, tbl[i].rec, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
         cyc();
         chk($sformatf("tbl%0d mem_req_valid", i), {63'd0, mem_req_valid}, {63'd0, tbl[i].e_req});
         chk($sformatf("tbl%0d mem_req_addr", i), {32'd0, mem_req_addr}, {32'd0, tbl[i].e_addr});
         chk($sformatf("tbl%0d dram_response_valid", i), {63'd0, dram_response_valid}, {63'd0, tbl[i].e_dv});
         chk($sformatf("tbl%0d dram_response", i), dram_response, tbl[i].e_resp);
         chk($sformatf("tbl%0d fill_PC", i), {32'd0, fill_PC}, {32'd0, tbl[i].e_fpc});
         chk($sformatf("tbl%0d busy", i), {63'd0, busy}, {63'd0, tbl[i].e_busy});
      end

      // Back-pressure: ready low three cycles, request held four, fill six edges after the miss edge.
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); cyc();
      set_in(1'b0, 1'b1, 32'h1018c, 1'b0, 1'b0, 1'b0, 32'h0); cyc();
      reqcnt = 0; fill_at = -1;
      for (int k = 1; k <= 20 && fill_at < 0; k++) begin
         if (mem_req_valid) begin
            reqcnt++;
            chk("bp mem_req_addr stable", {32'd0, mem_req_addr}, 64'h10188);
         end
         set_in(1'b0, 1'b1, 32'h1018c, 1'b0, (k >= 4), (k == 5 || k == 6),
                (k == 5) ? 32'h0badf00d : 32'hcafe0123);
         cyc();
         if (dram_response_valid) fill_at = k;
      end
      chk("bp request cycles", 64'(reqcnt), 64'd4);
      chk("bp fill latency", 64'(fill_at), 64'd6);
      chk("bp dram_response", dram_response, 64'hcafe0123_0badf00d);
      chk("bp fill_PC", {32'd0, fill_PC}, 64'h10188);

      // Redirect in BEAT0: both owed beats drained, no fill, then a clean miss.
      set_in(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); cyc();
      set_in(1'b0, 1'b1, 32'h101b0, 1'b0, 1'b0, 1'b0, 32'h0); cyc();
      chk("drain mem_req_addr", {32'd0, mem_req_addr}, 64'h101b0);
      set_in(1'b0, 1'b1, 32'h101b0, 1'b0, 1'b1, 1'b0, 32'h0); cyc();
      set_in(1'b0, 1'b1, 32'h101b0, 1'b1, 1'b0, 1'b0, 32'h0); cyc();
      chk("drain busy after redirect", {63'd0, busy}, 64'd1);
      dv_seen = dram_response_valid;
      set_in(1'b0, 1'b1, 32'h101b0, 1'b0, 1'b0, 1'b1, 32'h11111111); cyc();
      dv_seen |= dram_response_valid;
      set_in(1'b0, 1'b1, 32'h101b0, 1'b0, 1'b0, 1'b0, 32'h0); cyc();
      dv_seen |= dram_response_valid;
      chk("drain busy before last beat", {63'd0, busy}, 64'd1);
      set_in(1'b0, 1'b0, 32'h101b0, 1'b0, 1'b0, 1'b1, 32'h22222222); cyc();
      dv_seen |= dram_response_valid;
      chk("drain no fill", {63'd0, dv_seen}, 64'd0);
      chk("drain busy after beats", {63'd0, busy}, 64'd0);
      chk("drain dram_response held", dram_response, 64'd0);
      set_in(1'b0, 1'b1, 32'h1018c, 1'b0, 1'b0, 1'b0, 32'h0); cyc();
      set_in(1'b0, 1'b1, 32'h1018c, 1'b0, 1'b1, 1'b0, 32'h0); cyc();
      set_in(1'b0, 1'b1, 32'h1018c, 1'b0, 1'b0, 1'b1, 32'h33333333); cyc();
      set_in(1'b0, 1'b1, 32'h1018c, 1'b0, 1'b0, 1'b1, 32'h44444444); cyc();
      chk("refill valid", {63'd0, dram_response_valid}, 64'd1);
      chk("refill dram_response", dram_response, 64'h44444444_33333333);
      chk("refill fill_PC", {32'd0, fill_PC}, 64'h10188);

      // Reset while in BEAT1 clears every output.
      set_in(1'b0, 1'b1, 32'h10194, 1'b0, 1'b0, 1'b0, 32'h0); cyc();
      set_in(1'b0, 1'b1, 32'h10194, 1'b0, 1'b1, 1'b0, 32'h0); cyc();
      set_in(1'b0, 1'b1, 32'h10194, 1'b0, 1'b0, 1'b1, 32'h55555555); cyc();
      set_in(1'b1, 1'b1, 32'h10194, 1'b0, 1'b0, 1'b1, 32'h66666666); cyc();
      chk("rst busy", {63'd0, busy}, 64'd0);
      chk("rst mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
      chk("rst mem_req_addr", {32'd0, mem_req_addr}, 64'd0);
      chk("rst dram_response_valid", {63'd0, dram_response_valid}, 64'd0);
      chk("rst dram_response", dram_response, 64'd0);
      chk("rst fill_PC", {32'd0, fill_PC}, 64'd0);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 4000; i++) begin
         set_in(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), $urandom,
                ($urandom_range(0, 15) == 0), 1'($urandom), ($urandom_range(0, 2) != 0), $urandom);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
